// File: rtl/pc_fetch_control.sv
// Program counter register and fetch sequencer.
// Arbitrates idle/run/step/halt modes and counts executed cycles.
module pc_fetch_control #(
  parameter int NBITS = 32,
  parameter logic [NBITS-1:0] RESET_PC = '0,
  parameter int CNT_BITS = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_Run,
  input  logic                i_StepMode,
  input  logic                i_Step,
  input  logic                i_Stall,
  input  logic                i_Halt,
  input  logic [NBITS-1:0]    i_NextPC,
  output logic [NBITS-1:0]    o_PC,
  output logic [NBITS-1:0]    o_PC4,
  output logic                o_Fetch,
  output logic                o_Halted,
  output logic [CNT_BITS-1:0] o_CycleCount
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALTED
  } state_t;

  localparam logic [NBITS-1:0] PC_INC = NBITS'(4);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  state_t state, state_n;
  logic [NBITS-1:0] pc;
  logic [CNT_BITS-1:0] cnt;
  logic step_q;
  logic pending, pending_n;
  logic step_rise;
  logic advance;
  logic cnt_inc;

  assign step_rise = i_Step & ~step_q;

  always_comb begin
    state_n   = state;
    pending_n = pending;
    advance   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        pending_n = 1'b0;
        if (i_Run)
          state_n = i_StepMode ? STEP : RUN;
      end
      RUN: begin
        // Stalled and exiting cycles still count; the halt cycle does not.
        cnt_inc = ~i_Halt;
        if (i_Halt)
          state_n = HALTED;
        else if (!i_Run)
          state_n = IDLE;
        else
          advance = ~i_Stall;
      end
      STEP: begin
        if (i_Halt) begin
          state_n   = HALTED;
          pending_n = 1'b0;
        end else if (!i_Run) begin
          state_n   = IDLE;
          pending_n = 1'b0;
        end else if ((pending | step_rise) & ~i_Stall) begin
          advance   = 1'b1;
          cnt_inc   = 1'b1;
          pending_n = 1'b0;
        end else if (step_rise) begin
          pending_n = 1'b1;
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      cnt     <= '0;
      pending <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      step_q  <= i_Step;
      if (advance)
        pc <= {i_NextPC[NBITS-1:2], 2'b00};
      if (cnt_inc && (cnt != '1))
        cnt <= cnt + CNT_ONE;
    end
  end

  assign o_PC         = pc;
  assign o_PC4        = pc + PC_INC;
  assign o_Fetch      = advance;
  assign o_Halted     = (state == HALTED);
  assign o_CycleCount = cnt;

endmodule

// File: doc/pc_fetch_control.md
Name: pc_fetch_control

Overview:
- Program-counter register and fetch sequencer for the single-cycle/pipelined MIPS core.
- Sits directly downstream of the PC jump/branch selection mux: registers the selected next-PC and drives the instruction-memory address and the PC+4 adder input.
- Arbitrates execution mode from the debug unit (idle, continuous run, single step), hazard-unit stalls and HALT detection.
- Counts executed cycles for the debug unit.

Parameters:
- NBITS, 32, PC / address width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_BITS, 32, cycle counter width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous reset, active-low (0 = reset).
- i_Run  in  1  level from debug unit; 1 = execution enabled.
- i_StepMode  in  1  level; 1 = single-step mode, 0 = continuous; sampled only on leaving IDLE.
- i_Step  in  1  step request; rising edge detected internally.
- i_Stall  in  1  hazard-unit stall; PC holds.
- i_Halt  in  1  HALT instruction decoded at current PC.
- i_NextPC  in  NBITS  next PC from jump/branch mux.
- o_PC  out  NBITS  current PC / instruction-memory address.
- o_PC4  out  NBITS  o_PC + 4, combinational, wraps modulo 2^NBITS.
- o_Fetch  out  1  combinational; 1 = PC updates at next edge.
- o_Halted  out  1  registered; 1 in HALTED state.
- o_CycleCount  out  CNT_BITS  executed-cycle counter.

Behaviour:
Reset (async, i_reset=0): o_PC=RESET_PC; state=IDLE; o_Halted=0; o_CycleCount=0; step_pending=0; step edge register=0. Takes effect immediately, mid-operation included. No update occurs while reset is held.

States: IDLE, RUN, STEP, HALTED.
- IDLE: PC frozen; o_Fetch=0. If i_Run=1 at an edge: go to STEP if i_StepMode=1, else RUN. No PC update on the transition edge.
- RUN:
  - advance = ~i_Halt & ~i_Stall.
  - i_Halt=1 → HALTED next edge, PC not updated. Halt has priority over stall.
  - i_Run=0 → IDLE next edge, PC not updated. Takes priority over advance; halt has priority over i_Run=0.
  - Otherwise, if advance, o_PC <= {i_NextPC[NBITS-1:2],2'b00} (low bits forced to zero).
  - o_CycleCount increments every RUN cycle, stalls included, but not on the halt cycle.
- STEP:
  - step_pending is set by a rising edge of i_Step: i_Step=1 and previous sample 0.
  - advance = (step_pending | step edge this cycle) & ~i_Stall & ~i_Halt.
  - On advance: PC updates as in RUN; step_pending clears; o_CycleCount +1.
  - Stalled step: step_pending stays set, and the PC advances on the first non-stall cycle.
  - Holding i_Step high produces exactly one step.
  - A second edge while pending is absorbed; pending is not counted twice.
  - i_Halt=1 → HALTED; pending clears.
  - i_Run=0 → IDLE; pending clears.
- HALTED: o_Halted=1; PC and counter frozen; o_Fetch=0. Exits only via reset; i_Run, i_Step and i_Stall are ignored.

o_Fetch:
- Equals advance in RUN/STEP, and 0 otherwise.
- Latency: i_NextPC appears on o_PC one edge after a cycle with o_Fetch=1.

Counter:
- Saturates at all ones; no wrap.

Test Plan:
- Reset, i_Run=1, i_StepMode=0, i_NextPC=o_PC4 → o_PC reads 0, 4, 8, 12 on successive edges after the IDLE→RUN edge; o_CycleCount=3 after 3 RUN cycles.
- RUN, i_Stall=1 for 2 cycles at PC=8 → o_PC stays 8 for both; o_Fetch=0; counter still +2; resumes to 12 when stall drops.
- RUN at PC=0x10, i_Halt=1 together with i_Stall=1 → HALTED; o_Halted=1; PC stays 0x10; later i_Run toggles and i_Step pulses have no effect; only i_reset=0 returns PC to 0.
- STEP mode: i_Step held high 5 cycles → exactly one advance (0→4); step edge during i_Stall=1 → PC holds, then advances once when stall clears.
- i_NextPC=0x0000_0013 with advance → o_PC=0x0000_0010. o_PC=0xFFFF_FFFC → o_PC4=0x0000_0000.
- Assert i_reset=0 mid-RUN, asynchronously between edges → o_PC=RESET_PC, o_CycleCount=0, state IDLE immediately, before the next clock edge.
